// File: rtl/m_cordic_prerotate_pkg.sv
// Shared CORDIC constants: quadrant codes and guard width.
// Imported by the prerotate stage and the rotator chain.
package m_cordic_prerotate_pkg;

  localparam int GUARD_BITS = 2;
  localparam int CORDIC_BW  = 16;
  localparam int CORDIC_ZW  = 16;

  typedef enum logic [1:0] {
    QUAD_PASS_P = 2'b00,
    QUAD_POS90  = 2'b01,
    QUAD_NEG90  = 2'b10,
    QUAD_PASS_N = 2'b11
  } quad_e;

  function automatic quad_e quad_of(
    input logic [1:0] top
  );
    return quad_e'(top);
  endfunction

endpackage

// File: rtl/m_pipe_reg.sv
// Single valid/ready register slice.
// Loads when empty or when its contents leave this cycle.
module m_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         adv;

  always_comb begin
    adv     = !valid_q | out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (adv) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/m_cordic_prerotate.sv
// CORDIC input conditioning: guard-bit extension then
// +/-90 deg pre-rotation into the convergence range.
module m_cordic_prerotate
  import m_cordic_prerotate_pkg::*;
#(
  parameter int bitwidth = 16,
  parameter int zwidth   = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bitwidth-3:0] xi,
  input  logic [bitwidth-3:0] yi,
  input  logic [zwidth-1:0]   zi,
  input  logic                flag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [bitwidth-1:0] xo,
  output logic [bitwidth-1:0] yo,
  output logic [zwidth-1:0]   zo,
  output logic                flag_out
);

  localparam int PW = 2 * bitwidth + zwidth + 1;

  logic [bitwidth-1:0] x_ext;
  logic [bitwidth-1:0] y_ext;
  logic [PW-1:0]       s0_in;
  logic [PW-1:0]       s0_data;
  logic                s0_valid;
  logic                s0_rdy;
  logic                s1_rdy;

  logic [bitwidth-1:0] s0_x;
  logic [bitwidth-1:0] s0_y;
  logic [zwidth-1:0]   s0_z;
  logic                s0_f;

  logic [bitwidth-1:0] rot_x;
  logic [bitwidth-1:0] rot_y;
  logic [zwidth-1:0]   rot_z;
  logic [PW-1:0]       s1_in;
  logic [PW-1:0]       s1_data;
  quad_e               quad;

  always_comb begin
    x_ext = {{GUARD_BITS{xi[bitwidth-3]}}, xi};
    y_ext = {{GUARD_BITS{yi[bitwidth-3]}}, yi};
    s0_in = {x_ext, y_ext, zi, flag_in};
  end

  // Flush blocks acceptance so the flushed cycle never admits a sample.
  assign in_ready = s0_rdy & !flush;

  m_pipe_reg #(
    .W(PW)
  ) u_s0 (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid & !flush),
    .in_ready  (s0_rdy),
    .in_data   (s0_in),
    .out_valid (s0_valid),
    .out_ready (s1_rdy),
    .out_data  (s0_data)
  );

  assign {s0_x, s0_y, s0_z, s0_f} = s0_data;
  assign quad = quad_of(s0_z[zwidth-1:zwidth-2]);

  always_comb begin
    rot_x = s0_x;
    rot_y = s0_y;
    rot_z = s0_z;
    unique case (1'b1)
      (quad == QUAD_POS90): begin
        rot_x = -s0_y;
        rot_y = s0_x;
        rot_z = {2'b11, s0_z[zwidth-3:0]};
      end
      (quad == QUAD_NEG90): begin
        rot_x = s0_y;
        rot_y = -s0_x;
        rot_z = {2'b00, s0_z[zwidth-3:0]};
      end
      (quad == QUAD_PASS_P),
      (quad == QUAD_PASS_N): begin
        rot_x = s0_x;
        rot_y = s0_y;
        rot_z = s0_z;
      end
      default: begin
        rot_x = s0_x;
        rot_y = s0_y;
        rot_z = s0_z;
      end
    endcase
    s1_in = {rot_x, rot_y, rot_z, s0_f};
  end

  m_pipe_reg #(
    .W(PW)
  ) u_s1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (s0_valid),
    .in_ready  (s1_rdy),
    .in_data   (s1_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s1_data)
  );

  assign {xo, yo, zo, flag_out} = s1_data;

endmodule

// File: tb/tb_m_cordic_prerotate.sv
// Bench for m_cordic_prerotate: directed quadrant cases,
// random streams under backpressure, flush and async reset.
module tb_m_cordic_prerotate;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] xi;
  logic [13:0] yi;
  logic [15:0] zi;
  logic        flag_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] xo;
  logic [15:0] yo;
  logic [15:0] zo;
  logic        flag_out;

  m_cordic_prerotate #(
    .bitwidth(16),
    .zwidth  (16)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xi        (xi),
    .yi        (yi),
    .zi        (zi),
    .flag_in   (flag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xo        (xo),
    .yo        (yo),
    .zo        (zo),
    .flag_out  (flag_out)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int out_cnt  = 0;
  int flag_hits = 0;
  int flag_idx  = -1;

  logic [48:0] q[$];
  logic        s_ov, s_inx, s_outx;
  logic [48:0] s_out;
  logic        stall_prev = 1'b0;
  logic        flush_prev = 1'b0;
  logic [48:0] prev_out;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Quadrant rules expressed on the phase as an angle range.
  function automatic logic [48:0] ref_out(
    input logic [13:0] x,
    input logic [13:0] y,
    input logic [15:0] z,
    input logic        f
  );
    int xs, ys, zv, xr, yr, zr;
    xs = int'(x);
    ys = int'(y);
    if (xs >= 8192) xs -= 16384;
    if (ys >= 8192) ys -= 16384;
    zv = int'(z);
    if (zv >= 16384 && zv < 32768) begin
      xr = -ys; yr = xs; zr = zv + 32768;
    end else if (zv >= 32768 && zv < 49152) begin
      xr = ys; yr = -xs; zr = zv - 32768;
    end else begin
      xr = xs; yr = ys; zr = zv;
    end
    return {xr[15:0], yr[15:0], zr[15:0], f};
  endfunction

  task automatic step();
    logic exp_rdy;
    logic [48:0] e;
    @(negedge clock);
    cyc++;
    s_inx  = in_valid & in_ready;
    s_outx = out_valid & out_ready;
    s_ov   = out_valid;
    s_out  = {xo, yo, zo, flag_out};
    exp_rdy = !flush && !(q.size() == 2 && !out_ready);
    check("in_ready", in_ready, exp_rdy);
    if (stall_prev && !flush_prev) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", s_out, prev_out);
    end
    if (out_valid && q.size() == 0)
      check("spurious", out_valid, 0);
    else if (s_outx) begin
      e = q.pop_front();
      check("data", s_out, e);
      if (flag_out) begin
        flag_hits++;
        flag_idx = out_cnt;
      end
      out_cnt++;
    end
    if (s_inx) q.push_back(ref_out(xi, yi, zi, flag_in));
    if (flush) q.delete();
    stall_prev = out_valid & !out_ready;
    flush_prev = flush;
    prev_out   = s_out;
    @(posedge clock);
    #1;
  endtask

  task automatic directed(
    input string       tag,
    input logic [13:0] x,
    input logic [13:0] y,
    input logic [15:0] z,
    input logic [47:0] exp
  );
    out_ready = 1'b1;
    xi = x; yi = y; zi = z; flag_in = 1'b0;
    in_valid = 1'b1;
    step();
    check({tag, "_acc"}, s_inx, 1);
    in_valid = 1'b0;
    step();
    check({tag, "_lat1"}, s_ov, 0);
    step();
    check({tag, "_lat2"}, s_ov, 1);
    check(tag, s_out[48:1], exp);
  endtask

  function automatic logic pick_ready(input int mode);
    if (mode == 0) return (cyc % 3) == 0;
    if (mode == 1) return ($urandom_range(1) == 1);
    return ($urandom_range(3) != 0);
  endfunction

  task automatic feed_one(
    input int   mode,
    input logic f
  );
    int b;
    xi = 14'($urandom);
    yi = 14'($urandom);
    zi = 16'($urandom);
    flag_in = f;
    in_valid = 1'b1;
    b = 0;
    do begin
      out_ready = pick_ready(mode);
      step();
      b++;
    end while (!s_inx && b < 30);
    if (!s_inx) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    flag_in  = 1'b0;
  endtask

  task automatic drain(input int mode);
    int b;
    b = 0;
    while (q.size() != 0 && b < 60) begin
      out_ready = pick_ready(mode);
      step();
      b++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic run_stream(
    input int n,
    input int mode,
    input int fpos,
    input int gaps
  );
    out_cnt = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < $urandom_range(gaps); g++) begin
        out_ready = pick_ready(mode);
        step();
      end
      feed_one(mode, i == fpos);
    end
    drain(mode);
    check("out_count", out_cnt, n);
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    xi = '0; yi = '0; zi = '0; flag_in = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", {xo, yo, zo, flag_out}, 0);
    #21 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_ready", in_ready, 1);

    directed("pass", 14'h1000, 14'h0800, 16'h2000,
             {16'h1000, 16'h0800, 16'h2000});
    directed("pos90", 14'h1000, 14'h0800, 16'h6000,
             {16'hF800, 16'h1000, 16'hE000});
    directed("neg90", 14'h2000, 14'h1FFF, 16'h8000,
             {16'h1FFF, 16'h2000, 16'h0000});
    directed("z4000", 14'h0123, 14'h0456, 16'h4000,
             {16'hFBAA, 16'h0123, 16'hC000});
    directed("z3fff", 14'h0123, 14'h3456, 16'h3FFF,
             {16'h0123, 16'hF456, 16'h3FFF});
    directed("zc000", 14'h3ABC, 14'h0456, 16'hC000,
             {16'hFABC, 16'h0456, 16'hC000});

    run_stream(8, 0, -1, 0);

    flag_hits = 0;
    flag_idx  = -1;
    run_stream(5, 1, 2, 1);
    check("flag_hits", flag_hits, 1);
    check("flag_idx", flag_idx, 2);

    out_ready = 1'b0;
    feed_one(3, 1'b0);
    out_ready = 1'b0;
    feed_one(3, 1'b0);
    out_ready = 1'b0;
    flush = 1'b1;
    in_valid = 1'b1;
    step();
    check("flush_noacc", s_inx, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("flush_ov", s_ov, 0);
    for (int i = 0; i < 3; i++) step();

    out_ready = 1'b0;
    feed_one(3, 1'b1);
    out_ready = 1'b0;
    feed_one(3, 1'b0);
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", {xo, yo, zo, flag_out}, 0);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("arst_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("arst_quiet", s_ov, 0);

    run_stream(300, 2, -1, 2);
    run_stream(100, 1, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
